// File: rtl/voice_sched.sv
// voice_sched: round-robin arbiter sharing the voice-module command path
// between four requesters, with hold/gap pacing and a pre-emptive stop.
module voice_sched #(
    parameter int unsigned HOLD_CYCLES = 16,
    parameter int unsigned GAP_CYCLES  = 50_000_000,
    parameter logic [3:0]  STOP_CODE   = 4'hF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  req,
    input  logic [15:0] req_code,
    input  logic        stop,
    output logic [3:0]  select_voice,
    output logic        busy,
    output logic [3:0]  pend,
    output logic [1:0]  grant,
    output logic        drop
);

    localparam int unsigned NREQ    = 4;
    localparam int unsigned CODE_W  = 4;
    localparam int unsigned CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t                        state_q, state_d;
    logic [CNT_W-1:0]              cnt_q, cnt_d;
    logic [CODE_W-1:0]             sel_q, sel_d;
    logic [NREQ-1:0]               pend_q, pend_d;
    logic [NREQ-1:0][CODE_W-1:0]   code_q, code_d;
    logic [1:0]                    grant_q, grant_d;
    logic [1:0]                    ptr_q, ptr_d;
    logic                          drop_q, drop_d;
    logic                          busy_q;

    logic                          arb_hit;
    logic [1:0]                    arb_idx;

    // Round-robin search: first pending slot at or after ptr, wrapping mod 4
    always_comb begin
        arb_hit = 1'b0;
        arb_idx = ptr_q;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (pend_q[ptr_q + 2'(k)]) begin
                arb_hit = 1'b1;
                arb_idx = ptr_q + 2'(k);
            end
        end
    end

    // Next-state, slot update and output computation
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        pend_d  = pend_q;
        code_d  = code_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        drop_d  = 1'b0;

        if (stop) begin
            // Abort: flush every slot, including requests arriving now
            pend_d  = '0;
            sel_d   = STOP_CODE;
            cnt_d   = HOLD_LOAD;
            state_d = ISSUE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (arb_hit) begin
                        sel_d           = code_q[arb_idx];
                        pend_d[arb_idx] = 1'b0;
                        grant_d         = arb_idx;
                        ptr_d           = arb_idx + 2'd1;
                        cnt_d           = HOLD_LOAD;
                        state_d         = ISSUE;
                    end
                end
                ISSUE: begin
                    if (cnt_q == '0) begin
                        sel_d   = '0;
                        cnt_d   = GAP_LOAD;
                        state_d = GAP;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                GAP: begin
                    if (cnt_q == '0) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase

            // New requests win over a same-cycle grant; a code still waiting is overwritten
            for (int i = 0; i < NREQ; i++) begin
                if (req[i] && (req_code[CODE_W*i +: CODE_W] != '0)) begin
                    if (pend_d[i]) begin
                        drop_d = 1'b1;
                    end
                    pend_d[i] = 1'b1;
                    code_d[i] = req_code[CODE_W*i +: CODE_W];
                end
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            sel_q   <= '0;
            pend_q  <= '0;
            code_q  <= '0;
            grant_q <= '0;
            ptr_q   <= '0;
            drop_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            pend_q  <= pend_d;
            code_q  <= code_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            drop_q  <= drop_d;
            busy_q  <= (state_d != IDLE);
        end
    end

    assign select_voice = sel_q;
    assign busy         = busy_q;
    assign pend         = pend_q;
    assign grant        = grant_q;
    assign drop         = drop_q;

endmodule

// File: tb/tb_voice_sched.sv
// Bench for voice_sched: timestamp-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_voice_sched;

    localparam int unsigned H = 4;
    localparam int unsigned G = 10;
    localparam logic [3:0]  STOP = 4'hF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [15:0] req_code;
    logic        stop;
    logic [3:0]  select_voice;
    logic        busy;
    logic [3:0]  pend;
    logic [1:0]  grant;
    logic        drop;

    int vectors = 0;
    int miscompares = 0;

    voice_sched #(
        .HOLD_CYCLES (H),
        .GAP_CYCLES  (G),
        .STOP_CODE   (STOP)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .req_code     (req_code),
        .stop         (stop),
        .select_voice (select_voice),
        .busy         (busy),
        .pend         (pend),
        .grant        (grant),
        .drop         (drop)
    );

    always #5 clk = ~clk;

    // Reference model: commands are tracked by the edge index at which their
    // hold and busy windows end, not by a countdown state machine.
    logic [3:0] m_pend = '0;
    logic [3:0] m_code [4];
    int         m_ptr = 0;
    logic [1:0] m_grant = '0;
    logic [3:0] m_cmd = '0;
    logic [3:0] m_sel = '0;
    logic       m_busy = 1'b0;
    logic       m_drop = 1'b0;
    int         cyc = 0;
    int         hold_end = -1;
    int         busy_end = -1;
    int         a_idx;
    bit         a_found;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pend = '0; m_ptr = 0; m_grant = '0; m_cmd = '0;
            m_sel = '0; m_busy = 1'b0; m_drop = 1'b0;
            cyc = 0; hold_end = -1; busy_end = -1;
            for (int i = 0; i < 4; i++) m_code[i] = '0;
        end else begin
            cyc++;
            m_drop = 1'b0;
            if (stop) begin
                m_pend   = '0;
                m_cmd    = STOP;
                hold_end = cyc + H;
                busy_end = cyc + H + G;
            end else begin
                if (cyc > busy_end && m_pend != 4'b0000) begin
                    a_found = 0;
                    a_idx = 0;
                    for (int k = 0; k < 4; k++) begin
                        if (!a_found && m_pend[(m_ptr + k) % 4]) begin
                            a_found = 1;
                            a_idx = (m_ptr + k) % 4;
                        end
                    end
                    m_cmd = m_code[a_idx];
                    m_pend[a_idx] = 1'b0;
                    m_grant = 2'(a_idx);
                    m_ptr = (a_idx + 1) % 4;
                    hold_end = cyc + H;
                    busy_end = cyc + H + G;
                end
                for (int i = 0; i < 4; i++) begin
                    if (req[i] && req_code[4*i +: 4] != 4'h0) begin
                        if (m_pend[i]) m_drop = 1'b1;
                        m_pend[i] = 1'b1;
                        m_code[i] = req_code[4*i +: 4];
                    end
                end
            end
            m_sel  = (cyc < hold_end) ? m_cmd : 4'h0;
            m_busy = (cyc < busy_end);
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(posedge clk) begin
        bit bad;
        #1;
        bad = 0;
        vectors++;
        if (select_voice !== m_sel) begin
            bad = 1;
            $display("FAIL model select_voice t=%0t got %h expected %h", $time, select_voice, m_sel);
        end
        if (busy !== m_busy) begin
            bad = 1;
            $display("FAIL model busy t=%0t got %b expected %b", $time, busy, m_busy);
        end
        if (pend !== m_pend) begin
            bad = 1;
            $display("FAIL model pend t=%0t got %b expected %b", $time, pend, m_pend);
        end
        if (grant !== m_grant) begin
            bad = 1;
            $display("FAIL model grant t=%0t got %0d expected %0d", $time, grant, m_grant);
        end
        if (drop !== m_drop) begin
            bad = 1;
            $display("FAIL model drop t=%0t got %b expected %b", $time, drop, m_drop);
        end
        if (bad) miscompares++;
    end

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input logic [3:0] r, input logic [15:0] c);
        req = r;
        req_code = c;
        @(negedge clk);
        req = '0;
        req_code = '0;
    endtask

    initial begin
        bit found;
        rst_n = 1'b0;
        req = '0;
        req_code = '0;
        stop = 1'b0;
        tick(3);
        rst_n = 1'b1;

        // 1: idle after reset
        tick(20);
        chk("idle_sel", select_voice, 0);
        chk("idle_busy", busy, 0);
        chk("idle_pend", pend, 0);
        chk("idle_grant", grant, 0);
        chk("idle_drop", drop, 0);

        // 2: single request on slot 2
        pulse(4'b0100, 16'h0500);
        chk("t2_pend", pend, 4);
        chk("t2_sel_before", select_voice, 0);
        tick(1);
        chk("t2_sel", select_voice, 5);
        chk("t2_grant", grant, 2);
        chk("t2_busy", busy, 1);
        chk("t2_pend_clr", pend, 0);
        tick(3);
        chk("t2_sel_last", select_voice, 5);
        tick(1);
        chk("t2_sel_off", select_voice, 0);
        chk("t2_busy_gap", busy, 1);
        tick(9);
        chk("t2_busy_last", busy, 1);
        tick(1);
        chk("t2_busy_off", busy, 0);

        // 1b: asynchronous reset mid-ISSUE
        pulse(4'b0001, 16'h0003);
        tick(2);
        chk("rst_pre_sel", select_voice, 3);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_sel", select_voice, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pend", pend, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(2);

        // 3: four simultaneous requests, then a 1/0 burst
        pulse(4'b1111, 16'h4321);
        chk("t3_pend", pend, 15);
        tick(1);
        chk("t3_sel1", select_voice, 1);
        tick(15);
        chk("t3_sel2", select_voice, 2);
        tick(15);
        chk("t3_sel3", select_voice, 3);
        tick(15);
        chk("t3_sel4", select_voice, 4);
        chk("t3_grant3", grant, 3);
        tick(14);
        chk("t3_idle", busy, 0);
        req = 4'b0010; req_code = 16'h0080;
        @(negedge clk);
        req = 4'b0001; req_code = 16'h0009;
        @(negedge clk);
        req = '0; req_code = '0;
        chk("t3_sel8", select_voice, 8);
        chk("t3_grant1", grant, 1);
        tick(15);
        chk("t3_sel9", select_voice, 9);
        chk("t3_grant0", grant, 0);
        tick(14);

        // 4: overwrite while blocked, zero code ignored
        pulse(4'b0001, 16'h0002);
        pulse(4'b0010, 16'h0070);
        pulse(4'b0010, 16'h0090);
        chk("t4_drop", drop, 1);
        chk("t4_pend", pend, 2);
        tick(1);
        chk("t4_drop_off", drop, 0);
        pulse(4'b1000, 16'h0000);
        chk("t4_zero_pend", pend, 2);
        chk("t4_zero_drop", drop, 0);
        found = 0;
        for (int n = 0; n < 40 && !found; n++) begin
            tick(1);
            if (select_voice == 4'h9) found = 1;
        end
        chk("t4_wait_code9", found, 1);
        chk("t4_grant1", grant, 1);
        found = 0;
        for (int n = 0; n < 40 && !found; n++) begin
            tick(1);
            if (!busy) found = 1;
        end
        chk("t4_wait_idle", found, 1);
        tick(1);

        // 5: stop mid-GAP with slots 0 and 2 pending, same-cycle req discarded
        pulse(4'b0010, 16'h0010);
        pulse(4'b0101, 16'h0503);
        chk("t5_sel1", select_voice, 1);
        chk("t5_pend", pend, 5);
        tick(6);
        chk("t5_in_gap", select_voice, 0);
        stop = 1'b1; req = 4'b1000; req_code = 16'h2000;
        @(negedge clk);
        stop = 1'b0; req = '0; req_code = '0;
        chk("t5_stop_pend", pend, 0);
        chk("t5_stop_sel", select_voice, 15);
        chk("t5_stop_grant", grant, 1);
        chk("t5_stop_busy", busy, 1);
        tick(3);
        chk("t5_stop_hold", select_voice, 15);
        tick(1);
        chk("t5_stop_off", select_voice, 0);
        chk("t5_stop_gap", busy, 1);
        tick(20);
        chk("t5_after_pend", pend, 0);
        chk("t5_after_sel", select_voice, 0);
        chk("t5_after_busy", busy, 0);

        // 6: request on slot 0 in the cycle it is granted
        pulse(4'b0001, 16'h0004);
        pulse(4'b0001, 16'h0006);
        chk("t6_sel4", select_voice, 4);
        chk("t6_pend", pend, 1);
        chk("t6_drop", drop, 0);
        tick(15);
        chk("t6_sel6", select_voice, 6);
        chk("t6_grant0", grant, 0);
        tick(16);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
